// File: rtl/vdc_pkg.sv
// Shared definitions for the VDC RAM scheduler: command opcodes, block-engine
// states and the per-slot grant type.
package vdc_pkg;

    typedef enum logic [2:0] {
        OP_READ  = 3'd0,
        OP_WRITE = 3'd1,
        OP_FILL  = 3'd2,
        OP_COPY  = 3'd3
    } cmd_op_e;

    typedef enum logic [2:0] {
        ENG_IDLE,
        ENG_READ,
        ENG_WRITE,
        ENG_FILL,
        ENG_COPY_RD,
        ENG_COPY_WR
    } eng_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_RFSH,
        GNT_CH,
        GNT_ENG
    } grant_e;

endpackage

// File: rtl/vdc_blkengine.sv
// Block-move engine: READ / WRITE / FILL / COPY over the shared RAM port.
// It presents one access request per slot and advances only on granted slot ends.
module vdc_blkengine
    import vdc_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int WC_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd_op,
    input  logic                 cmd_dir,
    input  logic [ADDR_BITS-1:0] cmd_ua,
    input  logic [ADDR_BITS-1:0] cmd_ba,
    input  logic [WC_BITS-1:0]   cmd_wc,
    input  logic [7:0]           cmd_da,
    input  logic                 slot_done,
    input  logic [7:0]           ram_do,
    output logic                 cmd_ready,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_BITS-1:0] ua,
    output logic [ADDR_BITS-1:0] ba,
    output logic [7:0]           da,
    output logic [WC_BITS-1:0]   wc,
    output logic [ADDR_BITS-1:0] req_addr,
    output logic                 req_we,
    output logic [7:0]           req_wdata
);

    eng_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] ua_q, ua_d, ba_q, ba_d;
    logic [WC_BITS-1:0]   wc_q, wc_d;
    logic [7:0]           da_q, da_d, cpy_q, cpy_d;
    logic                 dir_q, dir_d, done_q, done_d;

    function automatic logic [ADDR_BITS-1:0] step_addr(input logic [ADDR_BITS-1:0] a,
                                                       input logic dn);
        return dn ? a - ADDR_BITS'(1) : a + ADDR_BITS'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENG_IDLE;
            ua_q    <= '0;
            ba_q    <= '0;
            wc_q    <= '0;
            da_q    <= '0;
            cpy_q   <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ua_q    <= ua_d;
            ba_q    <= ba_d;
            wc_q    <= wc_d;
            da_q    <= da_d;
            cpy_q   <= cpy_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    // A word count of zero wraps through the decrement, giving a full 2^WC_BITS block.
    always_comb begin
        state_d = state_q;
        ua_d    = ua_q;
        ba_d    = ba_q;
        wc_d    = wc_q;
        da_d    = da_q;
        cpy_d   = cpy_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            ENG_IDLE: begin
                if (cmd_valid && (cmd_op <= OP_COPY)) begin
                    ua_d  = cmd_ua;
                    ba_d  = cmd_ba;
                    wc_d  = cmd_wc;
                    da_d  = cmd_da;
                    dir_d = cmd_dir;
                    case (cmd_op)
                        OP_READ:  state_d = ENG_READ;
                        OP_WRITE: state_d = ENG_WRITE;
                        OP_FILL:  state_d = ENG_FILL;
                        default:  state_d = ENG_COPY_RD;
                    endcase
                end
            end
            ENG_READ: begin
                if (slot_done) begin
                    da_d    = ram_do;
                    state_d = ENG_IDLE;
                    done_d  = 1'b1;
                end
            end
            ENG_WRITE: begin
                if (slot_done) begin
                    ua_d    = step_addr(ua_q, dir_q);
                    state_d = ENG_READ;
                end
            end
            ENG_FILL: begin
                if (slot_done) begin
                    ua_d = step_addr(ua_q, dir_q);
                    wc_d = wc_q - WC_BITS'(1);
                    if (wc_q == WC_BITS'(1)) begin
                        state_d = ENG_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ENG_COPY_RD: begin
                if (slot_done) begin
                    cpy_d   = ram_do;
                    ba_d    = step_addr(ba_q, dir_q);
                    state_d = ENG_COPY_WR;
                end
            end
            ENG_COPY_WR: begin
                if (slot_done) begin
                    ua_d = step_addr(ua_q, dir_q);
                    wc_d = wc_q - WC_BITS'(1);
                    if (wc_q == WC_BITS'(1)) begin
                        state_d = ENG_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ENG_COPY_RD;
                    end
                end
            end
            default: state_d = ENG_IDLE;
        endcase
    end

    always_comb begin
        req_addr  = ua_q;
        req_we    = 1'b0;
        req_wdata = da_q;
        case (state_q)
            ENG_WRITE, ENG_FILL: req_we = 1'b1;
            ENG_COPY_RD:         req_addr = ba_q;
            ENG_COPY_WR: begin
                req_we    = 1'b1;
                req_wdata = cpy_q;
            end
            default: ;
        endcase
    end

    assign cmd_ready = (state_q == ENG_IDLE) && !reset;
    assign busy      = (state_q != ENG_IDLE);
    assign done      = done_q;
    assign ua        = ua_q;
    assign ba        = ba_q;
    assign da        = da_q;
    assign wc        = wc_q;

endmodule

// File: rtl/vdc_ramsched.sv
// VDC RAM slot scheduler: per-slot arbitration between refresh, display fetch
// channels and the block-move engine, driving a single-port RAM.
module vdc_ramsched
    import vdc_pkg::*;
#(
    parameter int ADDR_BITS = 16,
    parameter int NUM_CH    = 3,
    parameter int WC_BITS   = 8,
    parameter int RFSH_BITS = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             slot_start,
    input  logic                             slot_end,
    input  logic                             rfsh_en,
    input  logic [NUM_CH-1:0]                ch_req,
    input  logic [NUM_CH-1:0][ADDR_BITS-1:0] ch_addr,
    output logic [NUM_CH-1:0]                ch_valid,
    output logic [7:0]                       rd_data,
    input  logic                             cmd_valid,
    input  logic [2:0]                       cmd_op,
    input  logic                             cmd_dir,
    input  logic [ADDR_BITS-1:0]             cmd_ua,
    input  logic [ADDR_BITS-1:0]             cmd_ba,
    input  logic [WC_BITS-1:0]               cmd_wc,
    input  logic [7:0]                       cmd_da,
    output logic                             cmd_ready,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_BITS-1:0]             ua,
    output logic [ADDR_BITS-1:0]             ba,
    output logic [7:0]                       da,
    output logic [WC_BITS-1:0]               wc,
    output logic                             ram_rd,
    output logic                             ram_we,
    output logic [ADDR_BITS-1:0]             ram_addr,
    output logic [7:0]                       ram_di,
    input  logic [7:0]                       ram_do
);

    grant_e               grant_q, grant_d;
    logic [NUM_CH-1:0]    gnt_oh_q, gnt_oh_d;
    logic [NUM_CH-1:0]    low_oh;
    logic [NUM_CH-1:0]    ch_valid_q, ch_valid_d;
    logic [RFSH_BITS-1:0] rfsh_cnt_q, rfsh_cnt_d;
    logic [7:0]           rd_data_q, rd_data_d;
    logic                 ram_rd_q, ram_rd_d, ram_we_q, ram_we_d;
    logic [ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
    logic [7:0]           ram_di_q, ram_di_d;
    logic                 eng_slot_done;
    logic [ADDR_BITS-1:0] eng_addr;
    logic                 eng_we;
    logic [7:0]           eng_wdata;

    assign eng_slot_done = slot_end && (grant_q == GNT_ENG);
    assign low_oh        = ch_req & (~ch_req + NUM_CH'(1));

    vdc_blkengine #(
        .ADDR_BITS (ADDR_BITS),
        .WC_BITS   (WC_BITS)
    ) u_engine (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_ua    (cmd_ua),
        .cmd_ba    (cmd_ba),
        .cmd_wc    (cmd_wc),
        .cmd_da    (cmd_da),
        .slot_done (eng_slot_done),
        .ram_do    (ram_do),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .done      (done),
        .ua        (ua),
        .ba        (ba),
        .da        (da),
        .wc        (wc),
        .req_addr  (eng_addr),
        .req_we    (eng_we),
        .req_wdata (eng_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= GNT_NONE;
            gnt_oh_q   <= '0;
            ch_valid_q <= '0;
            rfsh_cnt_q <= '0;
            rd_data_q  <= '0;
            ram_rd_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '1;
            ram_di_q   <= '0;
        end else begin
            grant_q    <= grant_d;
            gnt_oh_q   <= gnt_oh_d;
            ch_valid_q <= ch_valid_d;
            rfsh_cnt_q <= rfsh_cnt_d;
            rd_data_q  <= rd_data_d;
            ram_rd_q   <= ram_rd_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
        end
    end

    // slot_end wins over a coincident slot_start and closes the grant so it cannot repeat.
    always_comb begin
        grant_d    = grant_q;
        gnt_oh_d   = gnt_oh_q;
        ch_valid_d = '0;
        rfsh_cnt_d = rfsh_cnt_q;
        rd_data_d  = rd_data_q;
        ram_rd_d   = 1'b0;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        if (slot_end) begin
            rd_data_d = ram_do;
            if (grant_q == GNT_CH) begin
                ch_valid_d = gnt_oh_q;
            end
            grant_d  = GNT_NONE;
            gnt_oh_d = '0;
        end else if (slot_start) begin
            gnt_oh_d = '0;
            if (rfsh_en) begin
                grant_d    = GNT_RFSH;
                ram_rd_d   = 1'b1;
                ram_addr_d = ADDR_BITS'(rfsh_cnt_q);
                rfsh_cnt_d = rfsh_cnt_q + RFSH_BITS'(1);
            end else if (|ch_req) begin
                grant_d  = GNT_CH;
                gnt_oh_d = low_oh;
                ram_rd_d = 1'b1;
                for (int k = 0; k < NUM_CH; k++) begin
                    if (low_oh[k]) begin
                        ram_addr_d = ch_addr[k];
                    end
                end
            end else if (busy) begin
                grant_d    = GNT_ENG;
                ram_rd_d   = !eng_we;
                ram_we_d   = eng_we;
                ram_addr_d = eng_addr;
                if (eng_we) begin
                    ram_di_d = eng_wdata;
                end
            end else begin
                grant_d    = GNT_NONE;
                ram_rd_d   = 1'b1;
                ram_addr_d = '1;
            end
        end
    end

    assign ch_valid = ch_valid_q;
    assign rd_data  = rd_data_q;
    assign ram_rd   = ram_rd_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_di   = ram_di_q;

endmodule

// File: doc/vdc_ramsched.md
VDC_RAMSCHED -- requirements
Module: vdc_ramsched

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, RAM word address width.
REQ-002 SHALL have parameter NUM_CH, default 3, number of display fetch channels.
REQ-003 SHALL have parameter WC_BITS, default 8, block word count width.
REQ-004 SHALL have parameter RFSH_BITS, default 8, refresh counter width.
REQ-005 SHALL have port: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: slot_start  in  1  column slot begin strobe; slot_end  in  1  column slot end strobe.
REQ-007 SHALL have ports: rfsh_en  in  1  refresh slot request; ch_req  in  NUM_CH  fetch requests; ch_addr  in  NUM_CH x ADDR_BITS  fetch addresses.
REQ-008 SHALL have ports: ch_valid  out  NUM_CH  one-hot data-valid pulse; rd_data  out  8  captured read data.
REQ-009 SHALL have ports: cmd_valid  in  1; cmd_op  in  3 (READ, WRITE, FILL, COPY); cmd_dir  in  1 (0 ascending, 1 descending); cmd_ua, cmd_ba  in  ADDR_BITS; cmd_wc  in  WC_BITS; cmd_da  in  8.
REQ-010 SHALL have ports: cmd_ready  out  1; busy  out  1; done  out  1 pulse; ua, ba  out  ADDR_BITS; da  out  8; wc  out  WC_BITS.
REQ-011 SHALL have ports: ram_rd, ram_we  out  1; ram_addr  out  ADDR_BITS; ram_di  out  8; ram_do  in  8.

Function
REQ-012 SHALL arbitrate once per slot on slot_start: refresh (rfsh_en) > ch_req lowest index > engine (busy) > idle.
REQ-013 SHALL drive ram_rd or ram_we as a one-cycle pulse in the slot_start cycle +1, with ram_addr/ram_di held until the next slot_start.
REQ-014 Refresh: ram_addr low RFSH_BITS = refresh counter, upper bits 0, ram_rd=1; counter increments modulo 2^RFSH_BITS.
REQ-015 Idle slot: ram_addr all-ones, ram_rd=1, no output pulse.
REQ-016 SHALL on slot_end capture ram_do into rd_data and pulse ch_valid[k] one cycle for the channel granted in that slot.
REQ-017 Engine states: IDLE, READ, WRITE, FILL, COPY_RD, COPY_WR; cmd_ready=1 only in IDLE and not reset.
REQ-018 cmd_valid with cmd_ready: load ua/ba/wc/da from cmd_*; WRITE/FILL use cmd_da; COPY->COPY_RD; READ->READ.
REQ-019 cmd_valid without cmd_ready SHALL be ignored with no state change.
REQ-020 READ slot: read ua; at slot_end da<=ram_do, ->IDLE, pulse done.
REQ-021 WRITE slot: write da to ua; at slot_end ua steps, ->READ (reload da from new ua).
REQ-022 FILL slot: write da to ua; at slot_end ua steps, wc decrements; wc==1 ->IDLE + done.
REQ-023 COPY_RD slot: read ba; at slot_end latch copy data, ba steps ->COPY_WR; COPY_WR writes latched data to ua, ua steps, wc decrements, wc==1 ->IDLE + done else ->COPY_RD.
REQ-024 Step = +1 (cmd_dir=0) or -1 (cmd_dir=1), modulo 2^ADDR_BITS; wrap without error.
REQ-025 cmd_wc=0 SHALL mean 2^WC_BITS words.
REQ-026 busy = engine not IDLE.
REQ-027 slot_start and slot_end in the same cycle: slot_end processed, slot_start ignored.
REQ-028 Engine advances only in slots it was granted; starved engine holds state indefinitely.

Reset
REQ-029 On reset: engine IDLE; ua, ba, wc, da, rd_data, refresh counter = 0; ch_valid, done, ram_rd, ram_we = 0; ram_addr all-ones; ram_di = 0.
REQ-030 Reset mid-block SHALL abort the operation with no done pulse; cmd_ready=1 the cycle after reset deasserts.

Structure
REQ-031 Engine state enum and cmd_op encoding (READ=0, WRITE=1, FILL=2, COPY=3) SHALL reside in shared package vdc_pkg.
REQ-032 The block-move engine SHALL be a sub-module vdc_blkengine; arbitration and RAM port remain in the top.

Verification
REQ-033 rfsh_en=1, ch_req=3'b011 at slot -> refresh address 0x0000+cnt issued, no ch_valid; next slot with rfsh_en=0 -> ch_valid=3'b001.
REQ-034 FILL ua=0x1000 wc=3 da=0xA5 dir=0, no fetches -> writes 0x1000..0x1002 = 0xA5, done after 3rd slot, ua=0x1003.
REQ-035 COPY ba=0x0000 ua=0xFFFF wc=2 dir=1 -> reads 0x0000,0xFFFF; writes 0xFFFF,0xFFFE; ba=0xFFFE, ua=0xFFFD.
REQ-036 WRITE ua=0x0010 da=0x5A -> write 0x0010, then READ 0x0011, da = RAM[0x0011], done pulse.
REQ-037 FILL wc=0 -> exactly 256 writes; reset asserted after 10 writes -> no done, cmd_ready=1 after reset.
REQ-038 cmd_valid while busy -> ignored; ch_req held every slot -> engine makes no progress until ch_req drops.
